// File: rtl/ifetch_align_if.sv
// rtl/ifetch_align_if.sv - instruction memory request/grant/response bus
interface ifetch_align_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    // Fetch unit side: issues word reads, consumes grant and response.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side: accepts word reads, returns grant and response.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_align.sv
// rtl/ifetch_align.sv - two-entry fetch buffer aligning 16/32-bit instructions at a halfword pc
module ifetch_align #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    ifetch_align_if.master  imem,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic            compressed,
    output logic            stall
);
    localparam int AW = XLEN - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_c;
    logic            wr_en;

    logic [1:0]      ent_valid_q;
    logic [AW-1:0]   ent_addr_q [0:1];
    logic [31:0]     ent_data_q [0:1];

    logic [AW-1:0]   w_addr;
    logic [AW-1:0]   n_addr;
    logic            w_hit, n_hit;
    logic [31:0]     w_data, n_data;
    logic            need_next;
    logic            valid_raw;
    logic            miss;
    logic [AW-1:0]   miss_addr;
    logic            victim;
    logic            unused_pc0;

    // pc is halfword aligned; bit 0 carries no information.
    assign unused_pc0 = pc[0];

    assign w_addr = pc[XLEN-1:2];
    assign n_addr = w_addr + AW'(1);

    // Look up the word at pc and the following word in the two entries.
    always_comb begin
        w_hit  = 1'b0;
        n_hit  = 1'b0;
        w_data = 32'h0;
        n_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            if (ent_valid_q[i] && ent_addr_q[i] == w_addr) begin
                w_hit  = 1'b1;
                w_data = ent_data_q[i];
            end
            if (ent_valid_q[i] && ent_addr_q[i] == n_addr) begin
                n_hit  = 1'b1;
                n_data = ent_data_q[i];
            end
        end
    end

    // Extract the instruction at pc; a 32-bit instruction in the upper half spills into the next word.
    always_comb begin
        instr     = 32'h0;
        valid_raw = 1'b0;
        need_next = 1'b0;
        if (!pc[1]) begin
            if (w_data[1:0] == 2'b11) begin
                instr = w_data;
            end else begin
                instr = {16'h0, w_data[15:0]};
            end
            valid_raw = w_hit;
        end else if (w_data[17:16] != 2'b11) begin
            instr     = {16'h0, w_data[31:16]};
            valid_raw = w_hit;
        end else begin
            instr     = {n_data[15:0], w_data[31:16]};
            need_next = 1'b1;
            valid_raw = w_hit && n_hit;
        end
    end

    assign instr_valid = valid_raw && !flush;
    assign compressed  = (instr[1:0] != 2'b11);
    assign stall       = !instr_valid;

    // The missing word: the one at pc first, then the spill word if the instruction straddles.
    always_comb begin
        miss      = 1'b0;
        miss_addr = w_addr;
        if (!w_hit) begin
            miss      = 1'b1;
            miss_addr = w_addr;
        end else if (need_next && !n_hit) begin
            miss      = 1'b1;
            miss_addr = n_addr;
        end
    end

    // Pick the entry to fill: a free one, else one not needed by the current pc, else entry 0.
    always_comb begin
        victim = 1'b0;
        if (!ent_valid_q[0]) begin
            victim = 1'b0;
        end else if (!ent_valid_q[1]) begin
            victim = 1'b1;
        end else if (ent_addr_q[0] != w_addr && ent_addr_q[0] != n_addr) begin
            victim = 1'b0;
        end else if (ent_addr_q[1] != w_addr && ent_addr_q[1] != n_addr) begin
            victim = 1'b1;
        end else begin
            victim = 1'b0;
        end
    end

    // Request FSM next state: one outstanding read, never withdrawn; flushed reads are drained in DROP.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        addr_d    = addr_q;
        req_c     = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss && !flush) begin
                    state_d = ST_REQ;
                    addr_d  = {miss_addr, 2'b00};
                end
            end
            ST_REQ: begin
                req_c = 1'b1;
                if (imem.imem_gnt) begin
                    state_d   = (flush || discard_q) ? ST_DROP : ST_WAIT;
                    discard_d = 1'b0;
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    state_d = ST_IDLE;
                    wr_en   = !flush;
                end else if (flush) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem.imem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_q;

    // Request FSM state, discard flag and held request address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
        end
    end

    // Buffer entries: flush invalidates both and wins over a fill in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid_q   <= 2'b00;
            ent_addr_q[0] <= '0;
            ent_addr_q[1] <= '0;
            ent_data_q[0] <= 32'h0;
            ent_data_q[1] <= 32'h0;
        end else if (flush) begin
            ent_valid_q <= 2'b00;
        end else if (wr_en) begin
            ent_valid_q[victim] <= 1'b1;
            ent_addr_q[victim]  <= addr_q[XLEN-1:2];
            ent_data_q[victim]  <= imem.imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_align.sv
// tb/tb_ifetch_align.sv - directed and randomized checks of ifetch_align against a memory image model
module tb_ifetch_align;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        compressed;
    logic        stall;

    ifetch_align_if #(.XLEN(XLEN)) bus ();

    ifetch_align #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .compressed  (compressed),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] mem [16];

    logic        rst_v, flush_v;
    logic [31:0] pc_v;
    int          gnt_mode;
    int          lat_fix;
    bit          stale_once;
    bit          pend_valid;
    logic [31:0] pend_addr;
    int          pend_cnt;
    bit          grant_s, rv_s;
    logic [31:0] gaddr_s;
    int          req_wait;
    logic [31:0] grants [$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] half_at(logic [31:0] a);
        logic [31:0] w;
        w = mem[a[5:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] ref_instr(logic [31:0] a);
        logic [15:0] h0;
        h0 = half_at(a);
        if (h0[1:0] != 2'b11) return {16'h0, h0};
        return {half_at(a + 32'd2), h0};
    endfunction

    function automatic logic ref_comp(logic [31:0] a);
        logic [15:0] h0;
        h0 = half_at(a);
        return h0[1:0] != 2'b11;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFC0 : 32'h0;
        return base + 32'(2 * $urandom_range(0, 31));
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rv_s) pend_valid = 1'b0;
        else if (pend_valid && pend_cnt > 0) pend_cnt--;
        if (grant_s) begin
            pend_valid = 1'b1;
            pend_addr  = gaddr_s;
            pend_cnt   = ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3))) - 1;
            grants.push_back(gaddr_s);
        end
        @(negedge clk);
        reset = rst_v;
        pc    = pc_v;
        flush = flush_v;
        if (gnt_mode == 0)      bus.imem_gnt = 1'b1;
        else if (gnt_mode == 1) bus.imem_gnt = 1'b0;
        else                    bus.imem_gnt = (req_wait >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        if (pend_valid && pend_cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = stale_once ? 32'hDEADBEEF : mem[pend_addr[5:2]];
            stale_once      = 1'b0;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
        end
        #1;
        grant_s  = bus.imem_req && bus.imem_gnt;
        gaddr_s  = bus.imem_addr;
        rv_s     = bus.imem_rvalid;
        req_wait = (bus.imem_req && !bus.imem_gnt) ? req_wait + 1 : 0;
    endtask

    task automatic reset_dut();
        rst_v   = 1'b1;
        flush_v = 1'b0;
        cyc();
        cyc();
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_stall", stall, 1);
        pend_valid = 1'b0;
        grant_s    = 1'b0;
        rv_s       = 1'b0;
        stale_once = 1'b0;
        req_wait   = 0;
        grants.delete();
        rst_v      = 1'b0;
    endtask

    task automatic wait_valid(string tag, int bound);
        for (int i = 0; i < bound; i++) begin
            if (instr_valid) break;
            cyc();
        end
        chk(tag, instr_valid, 1);
    endtask

    initial begin
        int since;
        bit was_wait;
        logic [31:0] was_addr;
        reset = 1'b1; pc = 32'h0; flush = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        rst_v = 1'b1; flush_v = 1'b0; pc_v = 32'h0;
        gnt_mode = 0; lat_fix = 1; stale_once = 1'b0;
        pend_valid = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
        grant_s = 1'b0; rv_s = 1'b0; gaddr_s = 32'h0; req_wait = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        // Basic latency: 32-bit instruction at pc 0.
        mem[0] = 32'h00000013; gnt_mode = 0; lat_fix = 1; pc_v = 32'h0;
        reset_dut();
        cyc();
        chk("t1_c0_req", bus.imem_req, 0);
        chk("t1_c0_valid", instr_valid, 0);
        cyc();
        chk("t1_c1_req", bus.imem_req, 1);
        chk("t1_c1_addr", bus.imem_addr, 32'h0);
        cyc();
        chk("t1_c2_valid", instr_valid, 0);
        cyc();
        chk("t1_c3_valid", instr_valid, 1);
        chk("t1_instr", instr, 32'h00000013);
        chk("t1_comp", compressed, 0);
        chk("t1_stall", stall, 0);

        // Two compressed halves of one word; second needs no new request.
        mem[0] = 32'h00854501; pc_v = 32'h0;
        reset_dut();
        cyc();
        wait_valid("t2_lo_timeout", 10);
        chk("t2_lo_instr", instr, 32'h00004501);
        chk("t2_lo_comp", compressed, 1);
        pc_v = 32'h2;
        cyc();
        chk("t2_hi_valid", instr_valid, 1);
        chk("t2_hi_instr", instr, 32'h00000085);
        chk("t2_hi_comp", compressed, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_no_req", bus.imem_req, 0);
        end
        chk("t2_grants", grants.size(), 1);

        // Straddling 32-bit instruction.
        mem[0] = 32'h00B34501; mem[1] = 32'h12340005; pc_v = 32'h2;
        reset_dut();
        cyc();
        wait_valid("t3_timeout", 20);
        chk("t3_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("t3_addr0", grants[0], 32'h0);
            chk("t3_addr1", grants[1], 32'h4);
        end
        chk("t3_instr", instr, 32'h000500B3);
        chk("t3_comp", compressed, 0);

        // Flush while waiting for data: response discarded, new W fetched.
        mem[0] = 32'h11112222; mem[2] = 32'h00000013; lat_fix = 3; pc_v = 32'h0;
        reset_dut();
        cyc();
        cyc();
        chk("t4_c1_req", bus.imem_req, 1);
        pc_v = 32'h8; flush_v = 1'b1; stale_once = 1'b1;
        cyc();
        chk("t4_flush_valid", instr_valid, 0);
        flush_v = 1'b0;
        cyc();
        chk("t4_drop_req", bus.imem_req, 0);
        cyc();
        cyc();
        chk("t4_idle_req", bus.imem_req, 0);
        cyc();
        chk("t4_new_req", bus.imem_req, 1);
        chk("t4_new_addr", bus.imem_addr, 32'h8);
        wait_valid("t4_timeout", 20);
        chk("t4_instr", instr, ref_instr(32'h8));
        pc_v = 32'h0;
        cyc();
        chk("t4_discarded", instr_valid, 0);

        // Flush while request not granted: address held, then drained.
        mem[4] = 32'h00010013; lat_fix = 1; gnt_mode = 1; pc_v = 32'h10;
        reset_dut();
        cyc();
        chk("t5_c0_req", bus.imem_req, 0);
        flush_v = 1'b1;
        cyc();
        chk("t5_c1_req", bus.imem_req, 1);
        chk("t5_c1_addr", bus.imem_addr, 32'h10);
        flush_v = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            if (i == 4) gnt_mode = 0;
            cyc();
            chk("t5_hold_req", bus.imem_req, 1);
            chk("t5_hold_addr", bus.imem_addr, 32'h10);
        end
        cyc();
        chk("t5_drop_req", bus.imem_req, 0);
        chk("t5_drop_valid", instr_valid, 0);
        cyc();
        chk("t5_ignored", instr_valid, 0);
        cyc();
        chk("t5_rereq", bus.imem_req, 1);
        chk("t5_rereq_addr", bus.imem_addr, 32'h10);
        wait_valid("t5_timeout", 20);
        chk("t5_instr", instr, ref_instr(32'h10));

        // Address wrap of the spill word.
        mem[15] = 32'h1237ABCD; mem[0] = 32'h5555AAAA; pc_v = 32'hFFFFFFFE;
        reset_dut();
        cyc();
        wait_valid("t6_timeout", 20);
        chk("t6_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("t6_addr0", grants[0], 32'hFFFFFFFC);
            chk("t6_addr1", grants[1], 32'h0);
        end
        chk("t6_instr", instr, ref_instr(32'hFFFFFFFE));
        chk("t6_comp", compressed, 0);

        // Reset in the middle of a transaction: stale response ignored.
        mem[0] = 32'h00000013; lat_fix = 3; pc_v = 32'h0;
        reset_dut();
        cyc();
        cyc();
        rst_v = 1'b1; stale_once = 1'b1;
        cyc();
        chk("t7_rst_req", bus.imem_req, 0);
        rst_v = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("t7_stale_ignored", instr_valid, 0);
        wait_valid("t7_timeout", 20);
        chk("t7_instr", instr, 32'h00000013);

        // Randomized pc/flush/grant/latency against the memory image.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        gnt_mode = 2; lat_fix = 0; pc_v = rand_pc();
        reset_dut();
        cyc();
        since = 0;
        for (int n = 0; n < 4000; n++) begin
            int r;
            was_wait = bus.imem_req && !bus.imem_gnt;
            was_addr = bus.imem_addr;
            r = $urandom_range(0, 31);
            flush_v = (r < 2);
            if (r < 7) begin
                pc_v  = rand_pc();
                since = 0;
            end
            cyc();
            chk("r_stall", stall, !instr_valid);
            if (flush) chk("r_flush_valid", instr_valid, 0);
            if (instr_valid) begin
                chk("r_instr", instr, ref_instr(pc));
                chk("r_comp", compressed, ref_comp(pc));
                since = 0;
            end else begin
                since++;
            end
            if (bus.imem_req) begin
                chk("r_addr_align", bus.imem_addr[1:0], 0);
                chk("r_single_outstanding", pend_valid, 0);
            end
            if (was_wait) begin
                chk("r_hold_req", bus.imem_req, 1);
                chk("r_hold_addr", bus.imem_addr, was_addr);
            end
            if (since > 40) begin
                chk("r_liveness", instr_valid, 1);
                since = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ifetch_align.md
IFETCH_ALIGN -- requirements
Module: ifetch_align

Interface
REQ-001 Parameter XLEN, default 32, SHALL set PC and memory address width.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-004 pc  in  XLEN  SHALL be the current PC from the PC stage, halfword aligned (pc[0]=0).
REQ-005 flush  in  1  SHALL signal a taken jump; all buffered and in-flight fetch data is discarded.
REQ-006 imem_req  out  1  SHALL request a word read from instruction memory.
REQ-007 imem_addr  out  XLEN  SHALL be the word-aligned read address (bits [1:0]=0).
REQ-008 imem_gnt  in  1  SHALL accept the request in any cycle where imem_req=1.
REQ-009 imem_rvalid  in  1  SHALL mark imem_rdata valid for the oldest granted request.
REQ-010 imem_rdata  in  32  SHALL carry the read word.
REQ-011 instr  out  32  SHALL carry the aligned instruction; compressed instructions are zero-extended in [15:0].
REQ-012 instr_valid  out  1  SHALL be 1 when instr holds the complete instruction at pc.
REQ-013 compressed  out  1  SHALL be 1 when instr[1:0]!=2'b11; feeds the PC stage increment select.
REQ-014 stall  out  1  SHALL equal !instr_valid; feeds the PC stage stall input.

Function
REQ-015 Buffer SHALL hold two entries, each {valid, word address, 32-bit data}.
REQ-016 W=pc[XLEN-1:2]; W+1 SHALL wrap modulo 2^(XLEN-2).
REQ-017 If pc[1]=0 and W buffered: instr = full word if low half [1:0]=11, else low half zero-extended.
REQ-018 If pc[1]=1 and W buffered: upper half [17:16]!=11 -> compressed, instr={16'h0,upper}; else needs W+1 buffered, instr={low half of W+1, upper half of W}.
REQ-019 instr_valid SHALL be combinational from buffer contents and pc, forced 0 while flush=1.
REQ-020 Miss address SHALL be W if W not buffered, else W+1 if REQ-018 requires it, else none.
REQ-021 FSM states IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-022 IDLE: miss and no flush -> REQ, latching imem_addr={miss address,2'b00}; else stay.
REQ-023 REQ: imem_req=1, imem_addr held stable until imem_gnt; gnt -> WAIT (DROP if flush same cycle).
REQ-024 REQ with flush and no gnt: stay REQ, set discard flag; on gnt -> DROP. Request is never withdrawn.
REQ-025 WAIT: rvalid -> write data to victim entry, -> IDLE; flush without rvalid -> DROP; flush with rvalid -> data discarded, -> IDLE.
REQ-026 DROP: rvalid -> data discarded, -> IDLE; flush in DROP keeps DROP.
REQ-027 Victim: first invalid entry (entry 0 preferred); else entry whose address is neither W nor W+1; else entry 0.
REQ-028 flush SHALL clear both valid bits at the next edge; a write in the same cycle is suppressed.
REQ-029 imem_rvalid in IDLE or REQ SHALL be ignored.
REQ-030 pc change without flush SHALL not cancel an outstanding request; response is still written.
REQ-031 Latency: buffered hit -> instr_valid same cycle; miss with gnt same cycle and rvalid next cycle -> instr_valid 3 cycles after miss first seen in IDLE.

Reset
REQ-032 On reset: state IDLE, both entries invalid, discard flag 0, imem_req=0, imem_addr=0, instr_valid=0, stall=1.
REQ-033 Reset asserted mid-transaction SHALL abandon it; a later rvalid arrives in IDLE and is ignored.
REQ-034 instr and compressed SHALL be don't-care while instr_valid=0.

Verification
REQ-035 Reset release, pc=0, gnt=1, rvalid one cycle after gnt, word0=32'h00000013 -> imem_addr=0, instr_valid=1 on 4th cycle, instr=32'h00000013, compressed=0.
REQ-036 pc=0, word0=32'h00854501 -> instr=32'h00004501, compressed=1; pc=2 -> instr=32'h00000085, compressed=1, no new request.
REQ-037 pc=2, word0=32'h00B3xxxx (upper half [1:0]=11), word1=32'hxxxx0005 -> requests addr 0 then 4; instr=32'h000500B3, compressed=0.
REQ-038 flush during WAIT, then rvalid with 32'hDEADBEEF -> data discarded, both entries invalid, new request issued for new W.
REQ-039 flush during REQ with gnt held low 3 cycles -> imem_addr stable until gnt, FSM enters DROP, following rvalid ignored.
REQ-040 pc=32'hFFFFFFFE, 32-bit instruction -> second request address 32'h00000000 (wrap).
